// File: rtl/pipe_control_pkg.sv
// rtl/pipe_control_pkg.sv - control bundle types, bubble constants and opcodes for pipe_control
package pipe_control_pkg;

  typedef enum logic [1:0] {
    DOADD    = 2'b00,
    TAKE3BIT = 2'b01,
    TAKE4BIT = 2'b10,
    BRANCH   = 2'b11
  } ALUop_t;

  typedef struct packed {
    logic RegWrite;
    logic MemtoReg;
    logic PCtoReg;
  } WB_ctrl;

  typedef struct packed {
    logic MemRead;
    logic CS;        // active-low data-memory select
    logic branch;
    logic jump;
    logic AddtoPC;
  } M_ctrl;

  typedef struct packed {
    logic [1:0] ALUsrc;
    ALUop_t     ALUop;
  } EX_ctrl;

  localparam WB_ctrl WB_CTRL_NOP = '{RegWrite: 1'b0, MemtoReg: 1'b0, PCtoReg: 1'b0};
  localparam M_ctrl  M_CTRL_NOP  = '{MemRead: 1'b0, CS: 1'b1, branch: 1'b0, jump: 1'b0, AddtoPC: 1'b0};
  localparam EX_ctrl EX_CTRL_NOP = '{ALUsrc: 2'b00, ALUop: DOADD};

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // What the stage registers do on a given cycle, in priority order below reset
  typedef enum logic [1:0] {
    ACT_ADVANCE = 2'b00,
    ACT_STALL   = 2'b01,
    ACT_FLUSH   = 2'b10,
    ACT_FREEZE  = 2'b11
  } pipe_act_e;

endpackage

// File: rtl/pipe_control_if.sv
// rtl/pipe_control_if.sv - datapath-facing signal bundle of pipe_control
interface pipe_control_if #(
  parameter int REG_AW = 5
);
  import pipe_control_pkg::*;

  logic              id_valid;
  logic [6:0]        id_opcode;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              mem_redirect;
  logic              mem_ready;

  EX_ctrl            ex_ctrl;
  logic [REG_AW-1:0] ex_rd;
  M_ctrl             mem_ctrl;
  WB_ctrl            wb_ctrl;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              illegal;
  logic              mem_timeout;

  modport master (
    output id_valid, id_opcode, id_rs1, id_rs2, id_rd, mem_redirect, mem_ready,
    input  ex_ctrl, ex_rd, mem_ctrl, wb_ctrl, pc_write, ifid_write, ifid_flush,
           illegal, mem_timeout
  );

  modport slave (
    input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, mem_redirect, mem_ready,
    output ex_ctrl, ex_rd, mem_ctrl, wb_ctrl, pc_write, ifid_write, ifid_flush,
           illegal, mem_timeout
  );

endinterface

// File: rtl/pipe_control_ctrl_decode.sv
// rtl/pipe_control_ctrl_decode.sv - combinational opcode decoder producing EX/M/WB bundles
module ctrl_decode
  import pipe_control_pkg::*;
(
  input  logic       i_valid,
  input  logic [6:0] i_opcode,
  output EX_ctrl     o_ex,
  output M_ctrl      o_m,
  output WB_ctrl     o_wb,
  output logic       o_illegal
);

  // Start from the bubble and switch on only the fields each opcode needs
  always_comb begin
    o_ex      = EX_CTRL_NOP;
    o_m       = M_CTRL_NOP;
    o_wb      = WB_CTRL_NOP;
    o_illegal = 1'b0;
    if (i_valid) begin
      unique case (i_opcode)
        OP_LOAD: begin
          o_wb.RegWrite = 1'b1;
          o_wb.MemtoReg = 1'b1;
          o_m.MemRead   = 1'b1;
          o_m.CS        = 1'b0;
          o_ex.ALUsrc   = 2'b10;
        end
        OP_IMM: begin
          o_wb.RegWrite = 1'b1;
          o_ex.ALUsrc   = 2'b10;
          o_ex.ALUop    = TAKE3BIT;
        end
        OP_AUIPC: begin
          o_wb.RegWrite = 1'b1;
          o_ex.ALUsrc   = 2'b11;
        end
        OP_STORE: begin
          o_m.CS        = 1'b0;
          o_ex.ALUsrc   = 2'b10;
        end
        OP_REG: begin
          o_wb.RegWrite = 1'b1;
          o_ex.ALUop    = TAKE4BIT;
        end
        OP_LUI: begin
          o_wb.RegWrite = 1'b1;
          o_ex.ALUsrc   = 2'b10;
        end
        OP_JALR: begin
          o_wb.RegWrite = 1'b1;
          o_wb.PCtoReg  = 1'b1;
          o_m.AddtoPC   = 1'b1;
          o_m.jump      = 1'b1;
          o_ex.ALUsrc   = 2'b10;
        end
        OP_JAL: begin
          o_wb.RegWrite = 1'b1;
          o_wb.PCtoReg  = 1'b1;
          o_m.jump      = 1'b1;
        end
        OP_BRANCH: begin
          o_m.branch    = 1'b1;
          o_ex.ALUop    = BRANCH;
        end
        default: o_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/pipe_control.sv
// rtl/pipe_control.sv - stage-aligned control pipeline with stall/flush/freeze; PERF_CNT_EN adds event counters
module pipe_control
  import pipe_control_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int MEM_WAIT_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  pipe_control_if.slave bus
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [31:0] freeze_cnt
`endif
);

  localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

  EX_ctrl            w_dec_ex;
  M_ctrl             w_dec_m;
  WB_ctrl            w_dec_wb;
  logic              w_dec_illegal;
  logic [REG_AW-1:0] w_dec_rd;

  EX_ctrl            r_idex_ex;
  M_ctrl             r_idex_m;
  WB_ctrl            r_idex_wb;
  logic [REG_AW-1:0] r_idex_rd;
  M_ctrl             r_exmem_m;
  WB_ctrl            r_exmem_wb;
  WB_ctrl            r_memwb_wb;
  logic [7:0]        r_wait_cnt;
  logic              r_illegal;
  logic              r_timeout;

  pipe_act_e         w_act;
  logic              w_freeze;
  logic              w_redirect;
  logic              w_loaduse;
  logic [7:0]        w_wait_inc;

  ctrl_decode u_decode (
    .i_valid   (bus.id_valid),
    .i_opcode  (bus.id_opcode),
    .o_ex      (w_dec_ex),
    .o_m       (w_dec_m),
    .o_wb      (w_dec_wb),
    .o_illegal (w_dec_illegal)
  );

  // Bubbles carry rd=0 so they can never look like a load-use producer
  assign w_dec_rd   = (bus.id_valid && !w_dec_illegal) ? bus.id_rd : '0;
  assign w_wait_inc = (r_wait_cnt == WAIT_MAX) ? r_wait_cnt : r_wait_cnt + 8'd1;

  // Hazard detection and cycle action: reset > freeze > redirect > load-use > advance
  always_comb begin
    w_freeze   = 1'b0;
    w_redirect = 1'b0;
    w_loaduse  = 1'b0;
    w_act      = ACT_ADVANCE;
    if (!rst) begin
      w_freeze   = !r_exmem_m.CS && !bus.mem_ready;
      w_redirect = !w_freeze && bus.mem_redirect;
      w_loaduse  = !w_freeze && !w_redirect && bus.id_valid && r_idex_m.MemRead &&
                   (r_idex_rd != '0) &&
                   ((r_idex_rd == bus.id_rs1) || (r_idex_rd == bus.id_rs2));
      if (w_freeze)        w_act = ACT_FREEZE;
      else if (w_redirect) w_act = ACT_FLUSH;
      else if (w_loaduse)  w_act = ACT_STALL;
    end
  end

  assign bus.pc_write    = !(w_freeze || w_loaduse);
  assign bus.ifid_write  = !(w_freeze || w_loaduse);
  assign bus.ifid_flush  = w_redirect;
  assign bus.ex_ctrl     = r_idex_ex;
  assign bus.ex_rd       = r_idex_rd;
  assign bus.mem_ctrl    = r_exmem_m;
  assign bus.wb_ctrl     = r_memwb_wb;
  assign bus.illegal     = r_illegal;
  assign bus.mem_timeout = r_timeout;

  // Stage registers: load, hold, or inject bubbles according to the cycle action
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idex_ex  <= EX_CTRL_NOP;
      r_idex_m   <= M_CTRL_NOP;
      r_idex_wb  <= WB_CTRL_NOP;
      r_idex_rd  <= '0;
      r_exmem_m  <= M_CTRL_NOP;
      r_exmem_wb <= WB_CTRL_NOP;
      r_memwb_wb <= WB_CTRL_NOP;
    end else begin
      unique case (w_act)
        ACT_FREEZE: ;
        ACT_FLUSH: begin
          r_idex_ex  <= EX_CTRL_NOP;
          r_idex_m   <= M_CTRL_NOP;
          r_idex_wb  <= WB_CTRL_NOP;
          r_idex_rd  <= '0;
          r_exmem_m  <= M_CTRL_NOP;
          r_exmem_wb <= WB_CTRL_NOP;
          r_memwb_wb <= r_exmem_wb;
        end
        ACT_STALL: begin
          r_idex_ex  <= EX_CTRL_NOP;
          r_idex_m   <= M_CTRL_NOP;
          r_idex_wb  <= WB_CTRL_NOP;
          r_idex_rd  <= '0;
          r_exmem_m  <= r_idex_m;
          r_exmem_wb <= r_idex_wb;
          r_memwb_wb <= r_exmem_wb;
        end
        default: begin
          r_idex_ex  <= w_dec_ex;
          r_idex_m   <= w_dec_m;
          r_idex_wb  <= w_dec_wb;
          r_idex_rd  <= w_dec_rd;
          r_exmem_m  <= r_idex_m;
          r_exmem_wb <= r_idex_wb;
          r_memwb_wb <= r_exmem_wb;
        end
      endcase
    end
  end

  // Memory-wait counter saturates at the limit; sticky timeout and illegal flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= 8'd0;
      r_timeout  <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      if (w_freeze) begin
        r_wait_cnt <= w_wait_inc;
        if (w_wait_inc == WAIT_MAX) r_timeout <= 1'b1;
      end else begin
        r_wait_cnt <= 8'd0;
      end
      if (w_dec_illegal) r_illegal <= 1'b1;
    end
  end

`ifdef PERF_CNT_EN
  // Wrapping event counters for stall, flush and freeze cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= 32'd0;
      flush_cnt  <= 32'd0;
      freeze_cnt <= 32'd0;
    end else begin
      if (w_loaduse)  stall_cnt  <= stall_cnt + 32'd1;
      if (w_redirect) flush_cnt  <= flush_cnt + 32'd1;
      if (w_freeze)   freeze_cnt <= freeze_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_control.sv
// tb/tb_pipe_control.sv - randomized and directed self-checking bench for pipe_control
module tb_pipe_control;
  import pipe_control_pkg::*;

  localparam int MAXW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_control_if #(.REG_AW(5)) bus ();

`ifdef PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt, freeze_cnt;
`endif

  pipe_control #(.REG_AW(5), .MEM_WAIT_MAX(MAXW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef PERF_CNT_EN
    ,
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt),
    .freeze_cnt (freeze_cnt)
`endif
  );

  typedef struct packed {
    EX_ctrl     ex;
    M_ctrl      m;
    WB_ctrl     wb;
    logic [4:0] rd;
  } instr_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: in-flight instructions as a 3-slot list (ID/EX, EX/MEM, MEM/WB)
  instr_t q[3];
  int     m_wait;
  bit     m_ill, m_to;
  int     m_stall, m_flush, m_freeze;

  function automatic instr_t bubble();
    instr_t t;
    t = '0;
    t.m.CS     = 1'b1;
    t.ex.ALUop = DOADD;
    return t;
  endfunction

  function automatic bit is_legal(logic [6:0] op);
    return op inside {7'b0000011, 7'b0010011, 7'b0010111, 7'b0100011, 7'b0110011,
                      7'b0110111, 7'b1100111, 7'b1101111, 7'b1100011};
  endfunction

  function automatic instr_t ref_decode(logic v, logic [6:0] op, logic [4:0] rd);
    instr_t t;
    t = bubble();
    if (!v || !is_legal(op)) return t;
    t.rd = rd;
    case (op)
      7'b0000011: begin t.wb.RegWrite = 1; t.wb.MemtoReg = 1; t.m.MemRead = 1; t.m.CS = 0; t.ex.ALUsrc = 2'b10; end
      7'b0010011: begin t.wb.RegWrite = 1; t.ex.ALUsrc = 2'b10; t.ex.ALUop = TAKE3BIT; end
      7'b0010111: begin t.wb.RegWrite = 1; t.ex.ALUsrc = 2'b11; end
      7'b0100011: begin t.m.CS = 0; t.ex.ALUsrc = 2'b10; end
      7'b0110011: begin t.wb.RegWrite = 1; t.ex.ALUop = TAKE4BIT; end
      7'b0110111: begin t.wb.RegWrite = 1; t.ex.ALUsrc = 2'b10; end
      7'b1100111: begin t.wb.RegWrite = 1; t.wb.PCtoReg = 1; t.m.AddtoPC = 1; t.m.jump = 1; t.ex.ALUsrc = 2'b10; end
      7'b1101111: begin t.wb.RegWrite = 1; t.wb.PCtoReg = 1; t.m.jump = 1; end
      default:    begin t.m.branch = 1; t.ex.ALUop = BRANCH; end
    endcase
    return t;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) q[i] = bubble();
    m_wait = 0; m_ill = 0; m_to = 0;
    m_stall = 0; m_flush = 0; m_freeze = 0;
  endtask

  // One clock: drive inputs after the falling edge, check against the model, advance the model
  task automatic step(input logic r, input logic v, input logic [6:0] op, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [4:0] d, input logic redir, input logic rdy);
    bit fz, rd_, lu;
    @(negedge clk);
    rst = r; bus.id_valid = v; bus.id_opcode = op; bus.id_rs1 = s1; bus.id_rs2 = s2;
    bus.id_rd = d; bus.mem_redirect = redir; bus.mem_ready = rdy;
    #1;
    fz  = !r && !q[1].m.CS && !rdy;
    rd_ = !r && !fz && redir;
    lu  = !r && !fz && !rd_ && v && q[0].m.MemRead && q[0].rd != 0 && (q[0].rd == s1 || q[0].rd == s2);
    check_eq("ex_ctrl",     32'(bus.ex_ctrl),  32'(q[0].ex));
    check_eq("ex_rd",       32'(bus.ex_rd),    32'(q[0].rd));
    check_eq("mem_ctrl",    32'(bus.mem_ctrl), 32'(q[1].m));
    check_eq("wb_ctrl",     32'(bus.wb_ctrl),  32'(q[2].wb));
    check_eq("pc_write",    32'(bus.pc_write),   32'(!(fz || lu)));
    check_eq("ifid_write",  32'(bus.ifid_write), 32'(!(fz || lu)));
    check_eq("ifid_flush",  32'(bus.ifid_flush), 32'(rd_));
    check_eq("illegal",     32'(bus.illegal),     32'(m_ill));
    check_eq("mem_timeout", 32'(bus.mem_timeout), 32'(m_to));
`ifdef PERF_CNT_EN
    check_eq("stall_cnt",  stall_cnt,  32'(m_stall));
    check_eq("flush_cnt",  flush_cnt,  32'(m_flush));
    check_eq("freeze_cnt", freeze_cnt, 32'(m_freeze));
`endif
    if (r) begin
      model_reset();
    end else begin
      if (v && !is_legal(op)) m_ill = 1;
      if (fz) begin
        m_freeze++;
        if (m_wait < MAXW) m_wait++;
        if (m_wait == MAXW) m_to = 1;
      end else begin
        m_wait = 0;
        q[2] = q[1];
        if (rd_) begin
          m_flush++;
          q[1] = bubble(); q[0] = bubble();
        end else if (lu) begin
          m_stall++;
          q[1] = q[0]; q[0] = bubble();
        end else begin
          q[1] = q[0]; q[0] = ref_decode(v, op, d);
        end
      end
    end
  endtask

  task automatic idle(input logic rdy);
    step(0, 0, 7'h00, 0, 0, 0, 0, rdy);
  endtask

  logic [6:0] ops[9] = '{7'b0000011, 7'b0010011, 7'b0010111, 7'b0100011, 7'b0110011,
                         7'b0110111, 7'b1100111, 7'b1101111, 7'b1100011};

  initial begin
    rst = 1'b1;
    bus.id_valid = 0; bus.id_opcode = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
    bus.mem_redirect = 0; bus.mem_ready = 1;
    repeat (2) @(posedge clk);
    model_reset();

    // Decode sweep, then an illegal opcode that must stick
    for (int i = 0; i < 9; i++) begin
      step(0, 1, ops[i], 5'd2, 5'd3, 5'd1, 0, 1);
      idle(1); idle(1);
    end
    step(0, 1, 7'b0001111, 0, 0, 5'd4, 0, 1);
    idle(1); idle(1); idle(1);

    // Load-use with rd=5, then with rd=0
    step(0, 1, OP_LOAD, 0, 0, 5'd5, 0, 1);
    step(0, 1, OP_REG, 5'd1, 5'd5, 5'd7, 0, 1);
    step(0, 1, OP_REG, 5'd1, 5'd5, 5'd7, 0, 1);
    idle(1); idle(1); idle(1);
    step(0, 1, OP_LOAD, 0, 0, 5'd0, 0, 1);
    step(0, 1, OP_REG, 5'd0, 5'd0, 5'd7, 0, 1);
    idle(1); idle(1); idle(1);

    // Redirect while a load-use hazard sits in ID
    step(0, 1, OP_BRANCH, 5'd1, 5'd2, 5'd0, 0, 1);
    step(0, 1, OP_LOAD, 0, 0, 5'd6, 0, 1);
    step(0, 1, OP_REG, 5'd6, 5'd1, 5'd8, 1, 1);
    idle(1); idle(1);

    // Store waits 3 cycles, then 9 cycles (timeout)
    step(0, 1, OP_STORE, 0, 0, 0, 0, 1);
    idle(1);
    repeat (3) idle(0);
    idle(1); idle(1);
    step(0, 1, OP_STORE, 0, 0, 0, 0, 1);
    idle(1);
    repeat (9) idle(0);
    idle(1); idle(1);

    // Freeze plus redirect: flush only once memory is ready
    step(0, 1, OP_LOAD, 0, 0, 5'd9, 0, 1);
    idle(1);
    repeat (2) step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    idle(1); idle(1);

    // Reset mid-freeze
    step(0, 1, OP_STORE, 0, 0, 0, 0, 1);
    idle(1);
    idle(0); idle(0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(1); idle(1);

    // Random traffic with small register numbers to provoke hazards
    for (int n = 0; n < 800; n++) begin
      logic [6:0] op;
      op = ($urandom_range(0, 19) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0), op,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_control.md
Name: pipe_control

Overview:
- Pipelined control unit for the 5-stage RISC-V core: decodes the opcode in ID and carries the EX/M/WB control bundles through the ID/EX, EX/MEM and MEM/WB registers.
- Generates load-use stalls, redirect flushes and data-memory wait freezes; flags illegal opcodes.
- Replaces the purely combinational per-opcode decoder; the datapath consumes the stage-aligned bundles directly.

Parameters:
- REG_AW, 5: register-address width for rs1/rs2/rd hazard compare.
- MEM_WAIT_MAX, 8: data-memory wait cycles before timeout is flagged; range 1..255.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-high.
- id_valid  in  1  IF/ID holds a valid instruction.
- id_opcode  in  7  instruction bits [6:0] in ID.
- id_rs1  in  REG_AW  source register 1 in ID.
- id_rs2  in  REG_AW  source register 2 in ID.
- id_rd  in  REG_AW  destination register in ID.
- mem_redirect  in  1  branch taken or jump resolved in MEM stage.
- mem_ready  in  1  data memory completes the access this cycle.
- ex_ctrl  out  EX_ctrl  ID/EX control bundle.
- ex_rd  out  REG_AW  ID/EX destination register.
- mem_ctrl  out  M_ctrl  EX/MEM control bundle.
- wb_ctrl  out  WB_ctrl  MEM/WB control bundle.
- pc_write  out  1  PC may update.
- ifid_write  out  1  IF/ID may load.
- ifid_flush  out  1  IF/ID loads a bubble.
- illegal  out  1  sticky: unknown opcode decoded.
- mem_timeout  out  1  sticky: wait reached MEM_WAIT_MAX.

Behaviour:
- Decode default: all fields 0, CS=1, ALUsrc=00, ALUop=DOADD. This default is the bubble (CTRL_NOP).
- Decode table (only the listed fields change from default):
  - 0000011: RegWrite, MemtoReg, MemRead, CS=0, ALUsrc=10.
  - 0010011: RegWrite, ALUsrc=10, ALUop=TAKE3BIT.
  - 0010111: RegWrite, ALUsrc=11.
  - 0100011: CS=0, ALUsrc=10.
  - 0110011: RegWrite, ALUop=TAKE4BIT.
  - 0110111: RegWrite, ALUsrc=10.
  - 1100111: RegWrite, PCtoReg, AddtoPC, jump, ALUsrc=10.
  - 1101111: RegWrite, PCtoReg, jump.
  - 1100011: branch, ALUop=BRANCH.
- Illegal: any other opcode with id_valid=1 decodes as a bubble and sets illegal.
- Invalid slot: id_valid=0 decodes as a bubble.
- Reset: all stage bundles = CTRL_NOP, ex_rd=0, illegal=0, mem_timeout=0, wait counter=0, pc_write=1, ifid_write=1, ifid_flush=0.
- Latency: a decoded bundle appears on ex_ctrl 1 cycle after ID, on mem_ctrl after 2 cycles, on wb_ctrl after 3 cycles.
- freeze = (mem_ctrl.CS==0) && !mem_ready.
  - All stage registers hold; pc_write=0; ifid_write=0; ifid_flush=0.
  - Wait counter increments and saturates at MEM_WAIT_MAX; reaching it sets mem_timeout. The freeze continues.
  - Counter clears on any non-freeze cycle.
- redirect = mem_redirect && !freeze.
  - ID/EX and EX/MEM load CTRL_NOP; MEM/WB takes EX/MEM normally.
  - ifid_flush=1; pc_write=1.
  - Load-use is ignored in the same cycle.
- loaduse = id_valid && ex_ctrl.MemRead && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2), evaluated only when neither freeze nor redirect is active.
  - ID/EX loads CTRL_NOP; pc_write=0; ifid_write=0.
  - Later stages advance.
  - Exactly 1 stall cycle per hazard.
- Priority: rst > freeze > redirect > loaduse > normal advance.
- pc_write, ifid_write and ifid_flush are combinational from current state and inputs; stage bundles are registered.
- rd=0 never triggers a stall.
- Reset asserted mid-freeze: all bundles return to NOP and the counter clears the next cycle.

Optional Feature:
- PERF_CNT_EN
  - Defined: adds 32-bit outputs stall_cnt, flush_cnt, freeze_cnt, counting loaduse, redirect and freeze cycles respectively. They wrap at 2^32 and clear on rst.
  - Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- my_pkg additions:
  - CTRL_NOP constants for WB_ctrl, M_ctrl and EX_ctrl.
  - Opcode localparams OP_LOAD, OP_IMM, OP_AUIPC, OP_STORE, OP_REG, OP_LUI, OP_JALR, OP_JAL, OP_BRANCH.
- Existing WB_ctrl, M_ctrl, EX_ctrl and the ALUop enum are reused unchanged.
- One sub-module: ctrl_decode. It is combinational, opcode+valid -> bundles + illegal, and implements the table above.
- pipe_control holds the stage registers, the hazard/freeze logic and the counters.

Test Plan:
- Decode sweep: each listed opcode with id_valid=1, 3 cycles per opcode.
  - Required: ex_ctrl matches the table 1 cycle later, mem_ctrl 2 cycles later, wb_ctrl 3 cycles later.
  - Opcode 0001111 gives a bubble and illegal=1, and illegal stays 1.
- Load-use: load rd=5, next instruction rs2=5.
  - Required: one cycle with pc_write=0, ifid_write=0, ex_ctrl=NOP; then the dependent instruction proceeds.
  - Same sequence with rd=0: no stall.
- Redirect: branch reaches MEM with mem_redirect=1 while a load hazard is present in ID.
  - Required: ifid_flush=1; ex_ctrl and mem_ctrl become NOP next cycle; pc_write=1; no stall.
- Memory wait, MEM_WAIT_MAX=8: store in MEM with mem_ready=0 for 3 cycles.
  - Required: all bundles hold for 3 cycles; pc_write=0; mem_timeout stays 0.
  - mem_ready=0 for 8 cycles: mem_timeout=1 after the 8th cycle.
- Freeze plus redirect: mem_redirect=1 with mem_ready=0 while a load is in MEM.
  - Required: no flush until mem_ready=1; the flush occurs in that cycle.
- Reset mid-freeze: rst=1 during wait.
  - Required: next cycle all bundles NOP, counters=0, pc_write=1.
